// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the EXE stage and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] lo_o;
    logic [WIDTH-1:0] hi_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  busy_o, stall_o, done_o, lo_o, hi_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output busy_o, stall_o, done_o, lo_o, hi_o
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multiply/divide unit: single-cycle multiply, radix-2 restoring divide.
// MULTDIV_DIVZERO_FAST_EN: divide by zero completes one cycle after accept.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           aclk,
    input  logic           rst,
    mult_div_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_ITER,
        S_DIV_FIX,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                      accept;
    logic                      in_signed;
    logic                      in_a_neg;
    logic                      in_b_neg;
    logic [WIDTH-1:0]          a_abs;
    logic [WIDTH-1:0]          b_abs;
    logic signed [WIDTH:0]     mul_a;
    logic signed [WIDTH:0]     mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH:0]            trial;
    logic [WIDTH-1:0]          quo_fix;
    logic [WIDTH-1:0]          rem_fix;
    logic                      last_iter;

    assign accept    = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;
    assign in_signed = ~bus.op_i[0];
    assign in_a_neg  = in_signed & bus.a_i[WIDTH-1];
    assign in_b_neg  = in_signed & bus.b_i[WIDTH-1];
    assign a_abs     = in_a_neg ? -bus.a_i : bus.a_i;
    assign b_abs     = in_b_neg ? -bus.b_i : bus.b_i;

    // One extra bit lets MULTU share the signed multiplier.
    assign mul_a = {~op_q[0] & a_q[WIDTH-1], a_q};
    assign mul_b = {~op_q[0] & b_q[WIDTH-1], b_q};
    assign prod  = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);

    // During divide a_q shifts out dividend bits and shifts in quotient bits.
    assign trial     = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign quo_fix   = (sa_q ^ sb_q) ? -a_q : a_q;
    assign rem_fix   = sa_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        if (bus.flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_d = bus.op_i;
                        if (!bus.op_i[1]) begin
                            a_d     = bus.a_i;
                            b_d     = bus.b_i;
                            state_d = S_MUL;
                        end else begin
                            a_d     = a_abs;
                            b_d     = b_abs;
                            sa_d    = in_a_neg;
                            sb_d    = in_b_neg;
                            rem_d   = '0;
                            cnt_d   = '0;
                            state_d = S_DIV_ITER;
`ifdef MULTDIV_DIVZERO_FAST_EN
                            if (bus.b_i == '0) begin
                                lo_d    = in_a_neg ? WIDTH'(1) : '1;
                                hi_d    = bus.a_i;
                                state_d = S_DONE;
                            end
`endif
                        end
                    end
                end
                S_MUL: begin
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                    state_d = S_DONE;
                end
                S_DIV_ITER: begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        a_d   = {a_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-2:0], a_q[WIDTH-1]};
                        a_d   = {a_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d = S_DIV_FIX;
                    end
                end
                S_DIV_FIX: begin
                    lo_d    = quo_fix;
                    hi_d    = rem_fix;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy_o  = (state_q != S_IDLE);
    assign bus.done_o  = (state_q == S_DONE);
    assign bus.stall_o = accept | (bus.busy_o & ~bus.done_o);
    assign bus.lo_o    = lo_q;
    assign bus.hi_o    = hi_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus randomized traffic vs a model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic aclk = 1'b0;
    logic rst;
    always #5 aclk = ~aclk;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .aclk (aclk),
        .rst  (rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // {hi, lo} straight from the arithmetic rules.
    function automatic logic [63:0] ref_res(logic [1:0] op, logic [31:0] a,
                                            logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (op)
            2'd0: begin
                q = sa * sb;
                p = q;
            end
            2'd1: p = ua * ub;
            2'd2: begin
                if (b == 32'd0) begin
                    p = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return p;
    endfunction

    function automatic int lat_of(logic [1:0] op, logic [31:0] b);
        if (!op[1]) return 2;
`ifdef MULTDIV_DIVZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return W + 2;
    endfunction

    // Model: latency countdown plus held results.
    bit          m_busy;
    int          m_rem;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge aclk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_rem  = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (bus.flush_i) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (bus.start_i) begin
                {p_hi, p_lo} = ref_res(bus.op_i, bus.a_i, bus.b_i);
                m_busy = 1'b1;
                m_rem  = lat_of(bus.op_i, bus.b_i) - 1;
                if (m_rem == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
        end else if (m_rem == 0) begin
            m_busy = 1'b0;
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
    end

    always @(negedge aclk) begin
        if (chk_en) begin
            logic e_done, e_stall;
            e_done  = m_busy && (m_rem == 0);
            e_stall = (bus.start_i & ~bus.flush_i & ~m_busy)
                    | (m_busy & ~e_done);
            chk("busy", bus.busy_o, m_busy);
            chk("done", bus.done_o, e_done);
            chk("stall", bus.stall_o, e_stall);
            chk("hi", bus.hi_o, m_hi);
            chk("lo", bus.lo_o, m_lo);
        end
    end

    task automatic wait_done(input int base, output int cyc);
        cyc = 0;
        for (int k = base; k <= base + 60; k++) begin
            @(negedge aclk);
            if (bus.done_o) begin
                cyc = k;
                return;
            end
            tick();
        end
    endtask

    task automatic run_op(string nm, logic [1:0] op, logic [31:0] a,
                          logic [31:0] b, int lat, logic [31:0] xlo,
                          logic [31:0] xhi);
        int cyc;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        tick();
        bus.start_i = 1'b0;
        wait_done(1, cyc);
        chk({nm, "_lat"}, cyc, lat);
        chk({nm, "_lo"}, bus.lo_o, xlo);
        chk({nm, "_hi"}, bus.hi_o, xhi);
        tick();
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc, dn;
        int dz_lat;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.op_i    = 2'd0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.flush_i = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        chk("model_mult", ref_res(2'd0, 32'hFFFF_FFFF, 32'd2),
            64'hFFFF_FFFF_FFFF_FFFE);
        chk("model_multu", ref_res(2'd1, 32'hFFFF_FFFF, 32'd2),
            64'h0000_0001_FFFF_FFFE);
        chk("model_div", ref_res(2'd2, 32'hFFFF_FFF9, 32'd2),
            64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_ovf", ref_res(2'd2, 32'h8000_0000, 32'hFFFF_FFFF),
            64'h0000_0000_8000_0000);

        @(negedge aclk);
        chk("rst_hi", bus.hi_o, 32'd0);
        chk("rst_lo", bus.lo_o, 32'd0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_done", bus.done_o, 1'b0);
        tick();

`ifdef MULTDIV_DIVZERO_FAST_EN
        dz_lat = 1;
`else
        dz_lat = 34;
`endif
        run_op("mult", 2'd0, 32'hFFFF_FFFF, 32'd2, 2,
               32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'd2, 2,
               32'hFFFF_FFFE, 32'd1);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 34,
               32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("divu", 2'd3, 32'd7, 32'd2, 34, 32'd3, 32'd1);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34,
               32'h8000_0000, 32'd0);
        run_op("divu_z", 2'd3, 32'd5, 32'd0, dz_lat,
               32'hFFFF_FFFF, 32'd5);
        run_op("div_z", 2'd2, 32'hFFFF_FFFB, 32'd0, dz_lat,
               32'd1, 32'hFFFF_FFFB);
        run_op("mult_pre", 2'd0, 32'd3, 32'd4, 2, 32'd12, 32'd0);

        // Flush in c10 of a divide.
        bus.start_i = 1'b1;
        bus.op_i    = 2'd2;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        tick();
        bus.start_i = 1'b0;
        repeat (9) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        @(negedge aclk);
        chk("flush_busy", bus.busy_o, 1'b0);
        dn = 0;
        repeat (40) begin
            tick();
            @(negedge aclk);
            dn += int'(bus.done_o);
        end
        chk("flush_nodone", dn, 0);
        chk("flush_lo", bus.lo_o, 32'd12);
        chk("flush_hi", bus.hi_o, 32'd0);
        tick();

        // Start together with flush is dropped.
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge aclk);
        chk("sflush_busy", bus.busy_o, 1'b0);
        tick();

        // Reset in c5 of a divide.
        bus.start_i = 1'b1;
        bus.op_i    = 2'd3;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        tick();
        bus.start_i = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge aclk);
        chk("mrst_busy", bus.busy_o, 1'b0);
        chk("mrst_hi", bus.hi_o, 32'd0);
        chk("mrst_lo", bus.lo_o, 32'd0);
        tick();

        // MULT request in c4 of a divide is ignored.
        bus.start_i = 1'b1;
        bus.op_i    = 2'd2;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        tick();
        bus.start_i = 1'b0;
        repeat (3) tick();
        bus.start_i = 1'b1;
        bus.op_i    = 2'd0;
        bus.a_i     = 32'd1;
        bus.b_i     = 32'd1;
        tick();
        bus.start_i = 1'b0;
        wait_done(5, cyc);
        chk("ign_lat", cyc, 34);
        chk("ign_lo", bus.lo_o, 32'd14);
        chk("ign_hi", bus.hi_o, 32'd2);
        tick();

        repeat (6000) begin
            bus.start_i = ($urandom_range(0, 2) == 0);
            bus.op_i    = 2'($urandom_range(0, 3));
            bus.a_i     = rnd32();
            bus.b_i     = rnd32();
            bus.flush_i = ($urandom_range(0, 60) == 0);
            rst         = ($urandom_range(0, 300) == 0);
            tick();
        end
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        rst         = 1'b0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised, self-contained multiply/divide unit for the EXE stage: signed/unsigned multiply and divide over `WIDTH`-bit operands, producing HI/LO results. Division uses an internal iterative radix-2 restoring divider; no vendor divider IP is used. The unit supports pipeline flush on exception, drives a stall request to the hazard unit, and holds its last HI/LO results until the next completion.

## Interface
- `WIDTH`, default 32. Operand and result width; must be even and at least 4.
- `CNT_W`, default `$clog2(WIDTH+1)`. Iteration counter width; derived, not overridden.

Ports:
- `aclk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  request; sampled only in IDLE.
- `op_i`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a_i`  in  WIDTH  multiplicand or dividend.
- `b_i`  in  WIDTH  multiplier or divisor.
- `flush_i`  in  1  exception flush; aborts any operation.
- `busy_o`  out  1  state != IDLE.
- `stall_o`  out  1  `(start_i & ~flush_i & state==IDLE) | (busy_o & ~done_o)`.
- `done_o`  out  1  one-cycle completion pulse.
- `lo_o`  out  WIDTH  product low half or quotient.
- `hi_o`  out  WIDTH  product high half or remainder.

## Operation
- States: IDLE, MUL, DIV_ITER, DIV_FIX, DONE.
- IDLE:
  - On `start_i & ~flush_i`, latch `op_i`, `a_i` and `b_i`.
  - MULT/MULTU go to MUL.
  - DIV/DIVU latch absolute values (signed only) and the two sign bits, clear the partial remainder and the counter, then go to DIV_ITER.
- MUL:
  - Operands are extended by 1 bit (sign or zero) and multiplied signed.
  - The low 2*WIDTH bits are written: `{hi_o, lo_o} <= product`. Go to DONE.
- DIV_ITER, one iteration per cycle:
  - Shift `{rem, quo}` left by 1 and trial-subtract `|b|` from `rem`.
  - If the result is non-negative, keep it and set the quotient LSB.
  - After WIDTH iterations, go to DIV_FIX.
- DIV_FIX:
  - Negate the quotient if the operand signs differ (signed op).
  - Negate the remainder if the dividend is negative (signed op).
  - Write quotient to `lo_o` and remainder to `hi_o`. Go to DONE.
- DONE: `done_o = 1`; return to IDLE. `start_i` in DONE is ignored, and `stall_o` is 0 in this cycle.
- Arithmetic rules:
  - The remainder takes the dividend's sign.
  - The most-negative dividend divided by -1 gives `lo = 1<<(WIDTH-1)`, `hi = 0`, with no trap.
  - Divide by zero, no macro: `lo` = all-ones (DIVU), or all-ones / 1 when the dividend is non-negative / negative (DIV). `hi = a`.
- `flush_i` in any state:
  - Next state is IDLE and `done_o` stays 0.
  - `hi_o`/`lo_o` keep their previous values.
  - Flush wins over a simultaneous `start_i`.
- `start_i` while busy is ignored; the operand registers are unchanged.
- Reset, including mid-operation: state IDLE, counter 0, `hi_o = lo_o = 0`, `busy_o = done_o = 0`.

## Timing
- Request accepted at the rising edge ending cycle c0.
- MULT/MULTU: MUL in c1, `done_o` in c2; results are valid from c2 and held.
- DIV/DIVU: DIV_ITER in c1..cWIDTH, DIV_FIX in cWIDTH+1, `done_o` in cWIDTH+2 (c34 for WIDTH=32).
- Back-to-back: the next request can be accepted in cycle c(done+1), when the state is IDLE.
- `stall_o` is combinational from `start_i` in IDLE; all other outputs are registered or decoded from state.

## Configuration
- `MULTDIV_DIVZERO_FAST_EN`
  - Defined: a DIV/DIVU with `b_i == 0` goes IDLE -> DONE directly, with `done_o` in c1. Results are the divide-by-zero values above, written at the accept edge.
  - Undefined: divide by zero takes the full WIDTH+2 latency and produces identical values.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002 -> `hi=0xFFFFFFFF`, `lo=0xFFFFFFFE`, `done_o` in c2. MULTU with the same operands -> `hi=0x00000001`, `lo=0xFFFFFFFE`.
- DIV a=0xFFFFFFF9 (-7), b=2 -> `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`, `done_o` in c34. DIVU 7/2 -> `lo=3`, `hi=1`.
- DIV a=0x80000000, b=0xFFFFFFFF -> `lo=0x80000000`, `hi=0`.
- DIVU 5/0 -> `lo=0xFFFFFFFF`, `hi=5`; `done_o` in c34 without the macro, c1 with `MULTDIV_DIVZERO_FAST_EN`. DIV -5/0 -> `lo=1`, `hi=0xFFFFFFFB`.
- DIV started, `flush_i` in c10 -> `busy_o=0` in c11, no `done_o`, `hi`/`lo` keep the prior MULT result. `start_i` with `flush_i` in the same cycle -> not accepted.
- `rst` in c5 of a DIV -> IDLE, `hi=lo=0` next cycle. A MULT issued in c4 of a DIV -> ignored, and the DIV result is still correct.
